// File: rtl/alu_pkg.sv
// Shared ALU definitions: FSM state encodings, default datapath width and opcodes.
package alu_pkg;

    localparam int unsigned DEFAULT_WIDTH = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [2:0] OP_SUM = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;

    typedef enum logic [1:0] {
        StIdle = ST_IDLE,
        StRun  = ST_RUN,
        StDone = ST_DONE
    } sub_state_t;

endpackage

// File: rtl/full_adder.sv
// One-bit full-adder cell, used as the bit-slice of the serial datapaths.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/serial_subtractor_4bits.sv
// Bit-serial a - b, LSB first, via one full-adder cell with inverted b and carry-in of 1.
// Results and flags are registered and held until the next operation completes.
module serial_subtractor_4bits
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             ovf
);

    localparam int unsigned CntW = $clog2(WIDTH);

    sub_state_t       r_state;
    logic [WIDTH-1:0] r_sa;
    logic [WIDTH-1:0] r_sb;
    logic [WIDTH-1:0] r_res;
    logic [CntW-1:0]  r_cnt;
    logic             r_c;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_diff;
    logic             r_borrow;
    logic             r_ovf;

    logic w_s;
    logic w_co;

    full_adder u_full_adder (
        .a  (r_sa[0]),
        .b  (r_sb[0]),
        .ci (r_c),
        .s  (w_s),
        .co (w_co)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= StIdle;
            r_sa     <= '0;
            r_sb     <= '0;
            r_res    <= '0;
            r_cnt    <= '0;
            r_c      <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_diff   <= '0;
            r_borrow <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            case (r_state)
                StIdle, StDone: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_sa    <= a;
                        r_sb    <= ~b;
                        r_c     <= 1'b1;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= StRun;
                    end else begin
                        r_state <= StIdle;
                    end
                end
                StRun: begin
                    r_sa  <= r_sa >> 1;
                    r_sb  <= r_sb >> 1;
                    r_c   <= w_co;
                    r_res <= {w_s, r_res[WIDTH-1:1]};
                    r_cnt <= r_cnt + CntW'(1);
                    if (r_cnt == CntW'(WIDTH - 1)) begin
                        // Overflow uses the carry into the MSB, i.e. the pre-update carry.
                        r_diff   <= {w_s, r_res[WIDTH-1:1]};
                        r_borrow <= ~w_co;
                        r_ovf    <= r_c ^ w_co;
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                        r_state  <= StDone;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign diff   = r_diff;
    assign borrow = r_borrow;
    assign ovf    = r_ovf;

endmodule

// File: tb/tb_serial_subtractor_4bits.sv
// Directed self-checking bench for serial_subtractor_4bits (WIDTH=4).
module tb_serial_subtractor_4bits;

    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] a;
    logic [3:0] b;
    logic       busy;
    logic       done;
    logic [3:0] diff;
    logic       borrow;
    logic       ovf;

    int checks;
    int errors;

    serial_subtractor_4bits #(
        .WIDTH(4)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .diff   (diff),
        .borrow (borrow),
        .ovf    (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse start for one edge, then count negedges until done (bounded).
    // lat counts edges from the start edge E0 up to and including E4 -> 5.
    task automatic run_op(input logic [3:0] ta, input logic [3:0] tb_v,
                          output int lat, output int busy_cyc);
        @(negedge clk);
        a = ta;
        b = tb_v;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        busy_cyc = 0;
        while (!done && lat < 20) begin
            if (busy) busy_cyc++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        start = 1'b0;
        a = '0;
        b = '0;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, diff, borrow, ovf} !== 8'h00) begin
            errors++;
            $display("FAIL reset_outputs got busy=%b done=%b diff=%h borrow=%b ovf=%b want all 0",
                     busy, done, diff, borrow, ovf);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_vectors;
        logic [3:0] va [7];
        logic [3:0] vb [7];
        logic [3:0] ed [7];
        logic       eb [7];
        logic       eo [7];
        int lat;
        int bc;
        va = '{4'h5, 4'h3, 4'h7, 4'h8, 4'h0, 4'hF, 4'h0};
        vb = '{4'h3, 4'h5, 4'hF, 4'h1, 4'h0, 4'hF, 4'h8};
        ed = '{4'h2, 4'hE, 4'h8, 4'h7, 4'h0, 4'h0, 4'h8};
        eb = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        eo = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 7; i++) begin
            run_op(va[i], vb[i], lat, bc);
            checks++;
            if (lat !== 5) begin
                errors++;
                $display("FAIL latency[%0d] got %0d want 5", i, lat);
            end
            checks++;
            if (bc !== 4) begin
                errors++;
                $display("FAIL busy_len[%0d] got %0d want 4", i, bc);
            end
            checks++;
            if ({diff, borrow, ovf} !== {ed[i], eb[i], eo[i]}) begin
                errors++;
                $display("FAIL result[%0d] %h-%h got diff=%h borrow=%b ovf=%b want diff=%h borrow=%b ovf=%b",
                         i, va[i], vb[i], diff, borrow, ovf, ed[i], eb[i], eo[i]);
            end
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || diff !== ed[i]) begin
                errors++;
                $display("FAIL hold[%0d] got done=%b diff=%h want done=0 diff=%h",
                         i, done, diff, ed[i]);
            end
        end
    endtask

    task automatic test_start_ignored;
        int lat;
        @(negedge clk);
        a = 4'h5;
        b = 4'h3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        a = 4'h9;
        b = 4'h1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (diff !== 4'h8) begin
            errors++;
            $display("FAIL stable_in_run got diff=%h want 8 (previous result)", diff);
        end
        lat = 3;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (lat !== 5 || {diff, borrow, ovf} !== {4'h2, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL start_ignored got lat=%0d diff=%h borrow=%b ovf=%b want lat=5 diff=2 0 0",
                     lat, diff, borrow, ovf);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL not_queued got busy=%b done=%b want 0 0", busy, done);
        end
    endtask

    task automatic test_back_to_back;
        a = 4'h7;
        b = 4'h2;
        start = 1'b1;
        for (int i = 1; i <= 15; i++) begin
            @(negedge clk);
            checks++;
            if (done !== (i % 5 == 0)) begin
                errors++;
                $display("FAIL b2b_done[%0d] got %b want %b", i, done, (i % 5 == 0));
            end
        end
        start = 1'b0;
        checks++;
        if (diff !== 4'h5) begin
            errors++;
            $display("FAIL b2b_diff got %h want 5", diff);
        end
        repeat (6) @(negedge clk);
    endtask

    task automatic test_reset_midrun;
        int seen;
        @(negedge clk);
        a = 4'h3;
        b = 4'h5;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({busy, done, diff, borrow, ovf} !== 8'h00) begin
            errors++;
            $display("FAIL async_reset got busy=%b done=%b diff=%h borrow=%b ovf=%b want all 0",
                     busy, done, diff, borrow, ovf);
        end
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done || busy) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL no_done_after_abort got %0d active cycles want 0", seen);
        end
    endtask

    task automatic test_after_reset;
        int lat;
        int bc;
        run_op(4'h0, 4'h1, lat, bc);
        checks++;
        if (lat !== 5 || {diff, borrow, ovf} !== {4'hF, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL after_reset got lat=%0d diff=%h borrow=%b ovf=%b want lat=5 diff=f 1 0",
                     lat, diff, borrow, ovf);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_vectors();
        test_start_ignored();
        test_back_to_back();
        test_reset_midrun();
        test_after_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_subtractor_4bits.md
# serial_subtractor_4bits

Bit-serial two's-complement subtractor computing `diff = a - b` one bit per clock, LSB first, using a single full-adder cell with `b` inverted and carry-in preset to 1. It is the inverse-operation counterpart to the parallel 4-bit adder in the ALU datapath. It trades latency for area and exposes a start/done handshake so the ALU controller can issue SUB operations alongside its SUM path. Outputs are the difference plus unsigned-borrow and signed-overflow flags.

## Interface

Parameters:
- `WIDTH`, default 4: operand and result width in bits; must be ≥ 2.

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `start` input 1: request a subtraction. Sampled only while `busy`=0.
- `a` input WIDTH: minuend, captured on the accepted `start` edge.
- `b` input WIDTH: subtrahend, captured on the accepted `start` edge.
- `busy` output 1: high while bits are being processed.
- `done` output 1: one-cycle pulse when the result becomes valid.
- `diff` output WIDTH: `a - b` modulo 2^WIDTH. Held until the next accepted start completes.
- `borrow` output 1: 1 when unsigned `a < b`, i.e. the inverse of the final carry-out.
- `ovf` output 1: signed overflow, equal to carry-into-MSB XOR carry-out-of-MSB.

## Operation

- **FSM states:** IDLE, RUN, DONE.
- **IDLE:**
  - On `start`=1, load `a` into shift register SA and `~b` into SB.
  - Set the carry register to 1 and the bit counter to 0.
  - Go to RUN.
- **RUN, each cycle:**
  - Full-adder cell computes `s = SA[0]^SB[0]^c` and `cout`.
  - `s` shifts into the MSB end of the result shift register; SA and SB shift right.
  - The carry register takes `cout`; the counter increments.
  - When processing the bit where counter = WIDTH-1:
    - latch `ovf = c ^ cout` using the pre-update carry `c`;
    - latch `borrow = ~cout`;
    - go to DONE.
- **DONE:**
  - `done`=1 and `busy`=0.
  - `diff`, `borrow` and `ovf` are updated from the result register in the transition into DONE.
  - A `start` seen in DONE is accepted exactly as in IDLE (back-to-back operation). Otherwise go to IDLE.
- **Start while busy:** `start` during RUN is ignored and is not queued.
- **Output stability:** `diff`, `borrow` and `ovf` change only on entry to DONE. They are stable through IDLE and through a following RUN.
- **Reset:**
  - State goes to IDLE immediately, at any time.
  - `busy`=0, `done`=0, `diff`=0, `borrow`=0, `ovf`=0.
  - Shift registers, carry and counter are cleared.
  - Reset in mid-RUN aborts the operation; no `done` is produced.
- **Width:** the counter is clog2(WIDTH) bits. No wrap beyond WIDTH-1 can occur, because the FSM leaves RUN at that count.

## Timing

- Edge E0: `start` sampled high in IDLE or DONE.
- Edges E1..EWIDTH: process bits 0..WIDTH-1.
- `busy`=1 from after E0 through EWIDTH.
- `done`=1 and results valid in the cycle after EWIDTH.
- Latency is WIDTH+1 cycles from the `start` edge to `done` (5 for WIDTH=4).
- Throughput: one result every WIDTH+1 cycles with `start` held high.
- No combinational path from inputs to outputs.

## Structure

- **Shared package (`alu_pkg`):**
  - state encoding constants `ST_IDLE`=2'd0, `ST_RUN`=2'd1, `ST_DONE`=2'd2;
  - default `WIDTH`=4;
  - a SUB opcode constant for the ALU controller.
- **Sub-module:** one instance of the existing `full_adder` cell as the bit-slice.
  - Its `b` is fed from SB, which already holds the inverted subtrahend.
  - Its `ci` comes from the carry register.
- No other hierarchy.

## Test plan

- `a`=5, `b`=3, `start` pulse → `done` on cycle 5; `diff`=4'h2, `borrow`=0, `ovf`=0. `busy` is high for exactly 4 cycles.
- `a`=3, `b`=5 → `diff`=4'hE, `borrow`=1, `ovf`=0.
- `a`=4'h7, `b`=4'hF (7 − (−1)) → `diff`=4'h8, `borrow`=1, `ovf`=1.
- `a`=4'h8, `b`=1 (−8 − 1) → `diff`=4'h7, `borrow`=0, `ovf`=1.
- Protocol checks:
  - `start` pulsed again 2 cycles into RUN with new operands → ignored; result reflects the first operands.
  - `start` held high continuously → `done` every 5 cycles.
- Reset checks:
  - `rst` asserted asynchronously mid-RUN → all outputs 0 immediately, no `done`.
  - Next `start` after reset → correct result.
